// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-ported data memory.
// Round-robin with a debug lock; reads take one extra cycle to return data.
module mem_port_arbiter #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  logic [0:0]    state;
  logic          last_owner;
  logic          owner;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;

  logic          arb_ok;
  logic          rd_done;
  logic          pick_dbg;

  assign arb_ok  = ~rst & (state == IDLE);
  assign rd_done = ~rst & (state == RD_WAIT);

  // Winner selection: locked debug keeps the port, else alternate on ties.
  always_comb begin
    pick_dbg = 1'b0;
    if (dbg_req && dbg_lock && (last_owner == OWN_DBG))
      pick_dbg = 1'b1;
    else if (dbg_req && cpu_req)
      pick_dbg = (last_owner == OWN_CPU);
    else
      pick_dbg = dbg_req;
  end

  assign cpu_gnt = arb_ok & cpu_req & ~pick_dbg;
  assign dbg_gnt = arb_ok & dbg_req & pick_dbg;

  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign cpu_rvalid = rd_done & (owner == OWN_CPU);
  assign dbg_rvalid = rd_done & (owner == OWN_DBG);

  // Memory strobe and operands come straight from the granted port.
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Read data is forwarded in the rvalid cycle and held afterwards.
  always_comb begin
    cpu_rdata = cpu_rdata_q;
    dbg_rdata = dbg_rdata_q;
    if (rst) begin
      cpu_rdata = '0;
      dbg_rdata = '0;
    end else begin
      if (cpu_rvalid) cpu_rdata = mem_rdata;
      if (dbg_rvalid) dbg_rdata = mem_rdata;
    end
  end

  // Port FSM: track last winner and the owner of an in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWN_DBG;
      owner      <= OWN_CPU;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_en) begin
            last_owner <= dbg_gnt;
            if (!mem_we) begin
              state <= RD_WAIT;
              owner <= dbg_gnt;
            end
          end
        end
        RD_WAIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-port read data holding registers, loaded only on their rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
    end
  end

endmodule
